// File: rtl/servo_step_sched.sv
// Motion-pattern scheduler for the pulso servo driver: drives the sel code for
// run_ms ticks, holds neutral for stop_ms ticks, and repeats reps times or until abort.
module servo_step_sched #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1_000,
  parameter int DUR_W   = 16,
  parameter int REP_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             dir_i,
  input  logic [DUR_W-1:0] run_ms_i,
  input  logic [DUR_W-1:0] stop_ms_i,
  input  logic [REP_W-1:0] reps_i,
  output logic [1:0]       sel_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [REP_W-1:0] rep_left_o,
  output logic [1:0]       dbg_state_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DUR_W-1:0] timer_q, timer_d;
  logic             dir_q, dir_d;
  logic [DUR_W-1:0] run_q, run_d;
  logic [DUR_W-1:0] stop_q, stop_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] rep_left_q, rep_left_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  assign tick = (presc_q == PW'(DIV - 1));

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    timer_d    = timer_q;
    dir_d      = dir_q;
    run_d      = run_q;
    stop_d     = stop_q;
    reps_d     = reps_q;
    rep_left_d = rep_left_q;

    // Phases are whole ticks long, so the free-running prescaler stays aligned
    // with every phase boundary once it is cleared on accept.
    if (state_q == RUN || state_q == PAUSE) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          dir_d      = dir_i;
          run_d      = run_ms_i;
          stop_d     = stop_ms_i;
          reps_d     = reps_i;
          rep_left_d = reps_i;
          presc_d    = '0;
          timer_d    = '0;
          if (run_ms_i != '0)       state_d = RUN;
          else if (stop_ms_i != '0) state_d = PAUSE;
          else                      state_d = DONE;
        end
      end
      RUN, PAUSE: begin
        if (abort_i) begin
          state_d = DONE;
        end else if (tick) begin
          if (timer_q == ((state_q == RUN) ? run_q : stop_q) - DUR_W'(1)) begin
            timer_d = '0;
            if (state_q == RUN && stop_q != '0) begin
              state_d = PAUSE;
            end else if (reps_q == '0) begin
              state_d = (run_q != '0) ? RUN : PAUSE;
            end else begin
              // End of a repetition: the decremented count shows from the next rep on.
              rep_left_d = rep_left_q - REP_W'(1);
              if (rep_left_q == REP_W'(1)) state_d = DONE;
              else                         state_d = (run_q != '0) ? RUN : PAUSE;
            end
          end else begin
            timer_d = timer_q + DUR_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sel_d  = (state_d == RUN) ? (dir_d ? 2'd2 : 2'd1) : 2'd0;
    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      timer_q    <= '0;
      dir_q      <= 1'b0;
      run_q      <= '0;
      stop_q     <= '0;
      reps_q     <= '0;
      rep_left_q <= '0;
      sel_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      timer_q    <= timer_d;
      dir_q      <= dir_d;
      run_q      <= run_d;
      stop_q     <= stop_d;
      reps_q     <= reps_d;
      rep_left_q <= rep_left_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sel_o       = sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rep_left_o  = rep_left_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_servo_step_sched.sv
// Bench for servo_step_sched: directed scenarios plus random patterns, each checked
// cycle by cycle against an expected queue built from the pattern's timing rules.
module tb_servo_step_sched;

  localparam int CLK_HZ  = 4000;
  localparam int TICK_HZ = 1000;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DUR_W   = 16;
  localparam int REP_W   = 8;
  localparam int W       = 2 + 1 + 1 + REP_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             dir;
  logic [DUR_W-1:0] run_ms;
  logic [DUR_W-1:0] stop_ms;
  logic [REP_W-1:0] reps;
  logic [1:0]       sel;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] rep_left;
  logic [1:0]       dbg_state;

  int               checks = 0;
  int               errors = 0;
  logic [W-1:0]     exp_q[$];
  logic [REP_W-1:0] last_rl;

  servo_step_sched #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DUR_W  (DUR_W),
    .REP_W  (REP_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .dir_i      (dir),
    .run_ms_i   (run_ms),
    .stop_ms_i  (stop_ms),
    .reps_i     (reps),
    .sel_o      (sel),
    .busy_o     (busy),
    .done_o     (done),
    .rep_left_o (rep_left),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input logic [1:0] s, input logic b, input logic d,
                                        input logic [REP_W-1:0] rl);
    return {s, b, d, rl};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] expv);
    logic [W-1:0] got;
    got = {sel, busy, done, rep_left};
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: sel/busy/done/rep_left got=%h required=%h", tag, got, expv);
    end
  endtask

  // Reference model: one entry per cycle after accept, from the phase lengths alone.
  task automatic build_exp(input bit d, input int n_run, input int n_stop, input int n_reps,
                           input int abort_at);
    logic [1:0]       code;
    logic [REP_W-1:0] rl;
    logic [W-1:0]     last;
    exp_q.delete();
    code = d ? 2'd2 : 2'd1;
    rl   = REP_W'(n_reps);
    if (n_run == 0 && n_stop == 0) begin
      exp_q.push_back(pack(2'd0, 1'b0, 1'b1, rl));
      last_rl = rl;
      return;
    end
    while (1) begin
      repeat (n_run * DIV)  exp_q.push_back(pack(code, 1'b1, 1'b0, rl));
      repeat (n_stop * DIV) exp_q.push_back(pack(2'd0, 1'b1, 1'b0, rl));
      if (abort_at != 0 && exp_q.size() >= abort_at) break;
      if (n_reps != 0) begin
        rl = rl - 1'b1;
        if (rl == 0) break;
      end
    end
    if (abort_at != 0) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      last = exp_q[exp_q.size()-1];
      rl   = last[REP_W-1:0];
    end
    exp_q.push_back(pack(2'd0, 1'b0, 1'b1, rl));
    last_rl = rl;
  endtask

  // driver: accept a pattern, scramble inputs while it runs, check every cycle
  task automatic run_pattern(input bit d, input int n_run, input int n_stop, input int n_reps,
                             input int abort_at, input string tag);
    build_exp(d, n_run, n_stop, n_reps, abort_at);
    dir     = d;
    run_ms  = DUR_W'(n_run);
    stop_ms = DUR_W'(n_stop);
    reps    = REP_W'(n_reps);
    start   = 1'b1;
    abort   = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      start   = 1'($urandom_range(0, 1));
      dir     = 1'($urandom);
      run_ms  = DUR_W'($urandom);
      stop_ms = DUR_W'($urandom);
      reps    = REP_W'($urandom);
      abort   = (k == abort_at);
      @(negedge clk);
      check(tag, exp_q[k-1]);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, pack(2'd0, 1'b0, 1'b0, last_rl));
    @(posedge clk); #1;
  endtask

  initial begin
    int n_run, n_stop, n_reps, len, ab;
    bit d;
    rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0;
    run_ms = '0; stop_ms = '0; reps = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", pack(2'd0, 1'b0, 1'b0, '0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_pattern(1'b1, 3, 2, 2, 0, "dir1_run3_stop2_x2");
    run_pattern(1'b0, 0, 0, 5, 0, "zero_length");
    run_pattern(1'b0, 1, 1, 0, 30, "continuous_abort");

    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", pack(2'd0, 1'b0, 1'b0, last_rl));
    @(posedge clk); #1;
    @(negedge clk);
    check("start_abort_idle2", pack(2'd0, 1'b0, 1'b0, last_rl));
    @(posedge clk); #1;

    // reset in the middle of a PAUSE phase
    dir = 1'b1; run_ms = 16'd1; stop_ms = 16'd3; reps = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("pause_before_rst", pack(2'd0, 1'b1, 1'b0, 8'd2));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_pause", pack(2'd0, 1'b0, 1'b0, '0));
    @(posedge clk); #1;
    @(negedge clk);
    check("no_done_after_rst", pack(2'd0, 1'b0, 1'b0, '0));
    @(posedge clk); #1;
    run_pattern(1'b0, 2, 1, 1, 0, "after_rst");

    for (int i = 0; i < 30; i++) begin
      d      = 1'($urandom);
      n_run  = $urandom_range(0, 4);
      n_stop = $urandom_range(0, 4);
      n_reps = $urandom_range(0, 3);
      ab     = 0;
      if (n_run != 0 || n_stop != 0) begin
        if (n_reps == 0) begin
          ab = $urandom_range(1, 50);
        end else begin
          len = (n_run + n_stop) * DIV * n_reps;
          if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, len);
        end
      end
      run_pattern(d, n_run, n_stop, n_reps, ab, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
